// File: rtl/led_fader_pkg.sv
// Shared widths, level type and saturating ramp arithmetic for the LED PWM fader.
package led_fader_pkg;

  localparam int PWM_BITS = 8;
  localparam int MAX      = (1 << PWM_BITS) - 1;

  typedef logic [PWM_BITS-1:0] level_t;

  localparam level_t LEVEL_MAX = level_t'(MAX);

  // One ramp step toward fully on (up=1) or fully off (up=0). The extra
  // bit catches both carry-out on the way up and borrow on the way down.
  function automatic level_t sat_step(input level_t level, input logic up,
                                      input level_t step);
    logic [PWM_BITS:0] wide;
    if (up) begin
      wide     = {1'b0, level} + {1'b0, step};
      sat_step = wide[PWM_BITS] ? LEVEL_MAX : wide[PWM_BITS-1:0];
    end else begin
      wide     = {1'b0, level} - {1'b0, step};
      sat_step = wide[PWM_BITS] ? level_t'(0) : wide[PWM_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level register, saturating ramp and PWM comparator.
module led_pwm_channel
  import led_fader_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                tick,
  input  logic                req,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                at_target
);

  localparam level_t STEP_L = level_t'(STEP);

  level_t level;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset is synchronous and lives inside the same block.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (tick) level <= sat_step(level, req, STEP_L);
      // Full scale is forced on so MAX never shows a one-count dark slot.
      led <= enable & ((level == LEVEL_MAX) | (level > pwm_cnt));
    end
  end

  assign at_target = (level == (req ? LEVEL_MAX : level_t'(0)));

endmodule

// File: rtl/led_pwm_fader.sv
// Fades each LED toward its PIO on/off request using a shared PWM counter.
module led_pwm_fader
  import led_fader_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PRESCALE = 50000,
  parameter int STEP     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_LEDS-1:0] led_req,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int                 PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  logic [NUM_LEDS-1:0] req_q;
  logic [NUM_LEDS-1:0] at_target;
  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  assign tick = enable & (presc == PRESC_LAST);

  // Request sampling runs regardless of enable; ramp timing freezes with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= '0;
      presc   <= '0;
      pwm_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      req_q <= led_req;
      busy  <= ~&at_target;
      if (enable) begin
        presc   <= tick ? '0 : presc + 1'b1;
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .STEP(STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .tick     (tick),
      .req      (req_q[i]),
      .pwm_cnt  (pwm_cnt),
      .led      (led_out[i]),
      .at_target(at_target[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: vector table, duty-cycle sequence and random run vs a reference model.
module tb_led_pwm_fader;

  localparam int NL        = 8;
  localparam int MAXL      = 255;
  localparam int PRESCALE  = 4;
  localparam int STEP      = 64;
  localparam int PRESCALE2 = 600;
  localparam int STEP2     = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, busy;
  logic [NL-1:0] led_req, led_out;
  logic          reset2, enable2, busy2;
  logic [NL-1:0] led_req2, led_out2;
  logic [7:0]    lvl0, lvl0_2;

  led_pwm_fader #(.NUM_LEDS(NL), .PRESCALE(PRESCALE), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .led_req(led_req), .led_out(led_out), .busy(busy)
  );

  led_pwm_fader #(.NUM_LEDS(NL), .PRESCALE(PRESCALE2), .STEP(STEP2)) dut2 (
    .clk(clk), .reset(reset2), .enable(enable2),
    .led_req(led_req2), .led_out(led_out2), .busy(busy2)
  );

  assign lvl0   = dut.g_ch[0].u_ch.level;
  assign lvl0_2 = dut2.g_ch[0].u_ch.level;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    int         n;
    int         exp_lvl;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: levels as plain integers clamped to [0, MAXL].
  int            m_lvl[NL];
  int            m_presc, m_pwm;
  logic [NL-1:0] m_req;
  logic [NL-1:0] exp_led;
  logic          exp_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick;
    tick = enable && (m_presc == PRESCALE - 1);
    if (reset) begin
      foreach (m_lvl[i]) m_lvl[i] = 0;
      m_presc  = 0;
      m_pwm    = 0;
      m_req    = '0;
      exp_led  = '0;
      exp_busy = 1'b0;
    end else begin
      exp_busy = 1'b0;
      for (int i = 0; i < NL; i++) begin
        exp_led[i] = enable && (m_lvl[i] == MAXL || m_lvl[i] > m_pwm);
        if (m_lvl[i] != (m_req[i] ? MAXL : 0)) exp_busy = 1'b1;
        if (tick) begin
          if (m_req[i]) m_lvl[i] = (m_lvl[i] + STEP > MAXL) ? MAXL : m_lvl[i] + STEP;
          else          m_lvl[i] = (m_lvl[i] < STEP) ? 0 : m_lvl[i] - STEP;
        end
      end
      m_req = led_req;
      if (enable) begin
        m_presc = (m_presc + 1) % PRESCALE;
        m_pwm   = (m_pwm + 1) % 256;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("led_out", led_out, exp_led);
    check("busy", busy, exp_busy);
    check("level0", lvl0, m_lvl[0]);
  endtask

  task automatic add(input logic rst, input logic en, input logic [7:0] req,
                     input int n, input int exp_lvl);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.n = n; v.exp_lvl = exp_lvl;
    vecs.push_back(v);
  endtask

  initial begin
    int hi;
    logic [NL-1:0] upper;

    reset = 1'b1; enable = 1'b1; led_req = '0;
    reset2 = 1'b1; enable2 = 1'b1; led_req2 = '0;

    // reset, ramp up
    add(1, 1, 8'h00, 2, 0);
    add(0, 1, 8'h01, 4, 64);  add(0, 1, 8'h01, 4, 128);
    add(0, 1, 8'h01, 4, 192); add(0, 1, 8'h01, 4, 255);
    add(0, 1, 8'h01, 4, 255);
    // ramp down with clamp at zero
    add(0, 1, 8'h00, 4, 191); add(0, 1, 8'h00, 4, 127);
    add(0, 1, 8'h00, 4, 63);  add(0, 1, 8'h00, 4, 0);
    add(0, 1, 8'h00, 4, 0);
    // reversal mid-ramp
    add(0, 1, 8'hFF, 4, 64);  add(0, 1, 8'hFF, 4, 128);
    add(0, 1, 8'h00, 4, 64);  add(0, 1, 8'h00, 4, 0);
    // enable freeze at 128, then resume with preserved phase
    add(0, 1, 8'hFF, 4, 64);  add(0, 1, 8'hFF, 4, 128);
    add(0, 0, 8'hFF, 100, 128);
    add(0, 1, 8'hFF, 4, 192);
    // reset mid-ramp, restart from zero
    add(1, 1, 8'h01, 1, 0);
    add(0, 1, 8'h01, 4, 64);  add(0, 1, 8'h01, 4, 128);

    foreach (vecs[k]) begin
      reset   = vecs[k].rst;
      enable  = vecs[k].en;
      led_req = vecs[k].req;
      repeat (vecs[k].n) cycle();
      check($sformatf("vec%0d level0", k), lvl0, vecs[k].exp_lvl);
    end

    // Duty cycle on the slow instance: one tick of 128 gives level 128 held for a long time.
    repeat (2) cycle();
    reset2   = 1'b0;
    led_req2 = 8'h01;
    repeat (PRESCALE2) cycle();
    check("dut2 level after 1 tick", lvl0_2, 128);
    repeat (2) cycle();
    hi = 0;
    upper = '0;
    repeat (256) begin
      cycle();
      if (led_out2[0]) hi++;
      upper |= led_out2 & 8'hFE;
    end
    check("duty 128/256", hi, 128);
    check("dut2 busy mid ramp", busy2, 1);
    repeat (PRESCALE2 - 250) cycle();
    check("dut2 level saturated", lvl0_2, 255);
    check("dut2 busy done", busy2, 0);
    hi = 0;
    repeat (256) begin
      cycle();
      if (led_out2[0]) hi++;
      upper |= led_out2 & 8'hFE;
    end
    check("duty full scale", hi, 256);
    check("dut2 idle channels dark", upper, 0);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 11) == 0) led_req = NL'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
